// File: rtl/restoring_divider_pkg.sv
// Shared divider definitions: controller state encodings.
// Pure declarations, no logic; no latency or backpressure of its own.
package restoring_divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/restoring_divider_adderk.sv
// k-bit ripple adder with carry-in: {carryout, s} = x + y + carryin.
// Combinational (zero latency); no handshake, no backpressure.
module adderk #(
   parameter int k = 6
) (
   input  logic         carryin,
   input  logic [k-1:0] x,
   input  logic [k-1:0] y,
   output logic [k-1:0] s,
   output logic         carryout
);

   assign {carryout, s} = {1'b0, x} + {1'b0, y} + {{k{1'b0}}, carryin};

endmodule

// File: rtl/restoring_divider.sv
// Unsigned restoring divider, one quotient bit per clock; result n edges after an accepted Start,
// or one edge when dividing by zero. Start is ignored while Busy (no queueing); Done holds until the next Start.
module restoring_divider
   import restoring_divider_pkg::*;
#(
   parameter int n = 5
) (
   input  logic         Clock,
   input  logic         Reset,
   input  logic         Start,
   input  logic [n-1:0] Dividend,
   input  logic [n-1:0] Divisor,
   output logic [n-1:0] Quotient,
   output logic [n-1:0] Remainder,
   output logic         Busy,
   output logic         Done,
   output logic         DivByZero
);

   localparam int CW = $clog2(n + 1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic [n-1:0]  r;
   logic [n-1:0]  q;
   logic [n-1:0]  dreg;

   logic [n:0]    t;
   logic [n:0]    s;
   logic          carry_unused;
   logic [n-1:0]  q_next;
   logic [n-1:0]  r_next;

   // The partial remainder always stays below the divisor, so n bits hold it;
   // the shifted-in value t still needs n+1 bits for the trial subtract.
   assign t = {r, q[n-1]};

   adderk #(.k(n + 1)) u_trial_sub (
      .carryin (1'b1),
      .x       (t),
      .y       (~{1'b0, dreg}),
      .s       (s),
      .carryout(carry_unused)
   );

   assign q_next = {q[n-2:0], ~s[n]};
   assign r_next = s[n] ? t[n-1:0] : s[n-1:0];

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state     <= IDLE;
         cnt       <= '0;
         r         <= '0;
         q         <= '0;
         dreg      <= '0;
         Quotient  <= '0;
         Remainder <= '0;
         Busy      <= 1'b0;
         Done      <= 1'b0;
         DivByZero <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (Start) begin
                  if (Divisor == '0) begin
                     state     <= DONE;
                     Quotient  <= '1;
                     Remainder <= Dividend;
                     Busy      <= 1'b0;
                     Done      <= 1'b1;
                     DivByZero <= 1'b1;
                  end else begin
                     state     <= RUN;
                     cnt       <= '0;
                     r         <= '0;
                     q         <= Dividend;
                     dreg      <= Divisor;
                     Quotient  <= '0;
                     Remainder <= '0;
                     Busy      <= 1'b1;
                     Done      <= 1'b0;
                     DivByZero <= 1'b0;
                  end
               end
            end
            RUN: begin
               r   <= r_next;
               q   <= q_next;
               cnt <= cnt + CW'(1);
               // Final step lands its result directly in the output registers.
               if (cnt == CW'(n - 1)) begin
                  state     <= DONE;
                  Quotient  <= q_next;
                  Remainder <= r_next;
                  Busy      <= 1'b0;
                  Done      <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_restoring_divider.sv
// Directed and randomized checks of restoring_divider against hand-computed and / % results.
module tb_restoring_divider;

   localparam int N = 5;

   logic         Clock = 1'b0;
   logic         Reset;
   logic         Start;
   logic [N-1:0] Dividend;
   logic [N-1:0] Divisor;
   logic [N-1:0] Quotient;
   logic [N-1:0] Remainder;
   logic         Busy;
   logic         Done;
   logic         DivByZero;

   int checks   = 0;
   int failures = 0;

   always #5 Clock = ~Clock;

   restoring_divider #(.n(N)) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .Start    (Start),
      .Dividend (Dividend),
      .Divisor  (Divisor),
      .Quotient (Quotient),
      .Remainder(Remainder),
      .Busy     (Busy),
      .Done     (Done),
      .DivByZero(DivByZero)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b);
      Dividend = a;
      Divisor  = b;
      Start    = 1'b1;
      tick();
      Start    = 1'b0;
   endtask

   // Start a division and check Busy/Done timing and the final result.
   task automatic run_div(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] expq, input logic [N-1:0] expr, input bit full);
      launch(a, b);
      if (b == '0) begin
         chk({tag, "_done"}, Done, 1);
         chk({tag, "_dbz"}, DivByZero, 1);
         chk({tag, "_busy"}, Busy, 0);
      end else begin
         for (int i = 0; i < N; i++) begin
            if (full) begin
               chk({tag, "_busy_run"}, Busy, 1);
               chk({tag, "_done_run"}, Done, 0);
               chk({tag, "_q_run"}, Quotient, 0);
            end
            tick();
         end
         chk({tag, "_done"}, Done, 1);
         chk({tag, "_busy"}, Busy, 0);
         chk({tag, "_dbz"}, DivByZero, 0);
      end
      chk({tag, "_q"}, Quotient, expq);
      chk({tag, "_r"}, Remainder, expr);
   endtask

   initial begin
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [N-1:0] eq;
      logic [N-1:0] er;

      Reset    = 1'b1;
      Start    = 1'b0;
      Dividend = '0;
      Divisor  = '0;
      tick();
      tick();
      chk("rst_busy", Busy, 0);
      chk("rst_done", Done, 0);
      chk("rst_dbz", DivByZero, 0);
      chk("rst_q", Quotient, 0);
      chk("rst_r", Remainder, 0);
      Reset = 1'b0;
      tick();
      chk("idle_done", Done, 0);

      run_div("t1_23_5", 5'd23, 5'd5, 5'd4, 5'd3, 1'b1);
      tick();
      tick();
      chk("t1_hold_done", Done, 1);
      chk("t1_hold_q", Quotient, 4);
      chk("t1_hold_r", Remainder, 3);

      run_div("t2_31_1", 5'd31, 5'd1, 5'd31, 5'd0, 1'b1);
      run_div("t2_3_9", 5'd3, 5'd9, 5'd0, 5'd3, 1'b1);
      run_div("t2_0_7", 5'd0, 5'd7, 5'd0, 5'd0, 1'b1);

      run_div("t3_7_0", 5'd7, 5'd0, 5'd31, 5'd7, 1'b1);
      tick();
      chk("t3_hold_busy", Busy, 0);
      chk("t3_hold_done", Done, 1);
      chk("t3_hold_dbz", DivByZero, 1);

      // Start re-asserted with new operands during the second RUN cycle.
      launch(5'd23, 5'd5);
      chk("t4_busy0", Busy, 1);
      tick();
      Dividend = 5'd30;
      Divisor  = 5'd2;
      Start    = 1'b1;
      tick();
      Start    = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("t4_busy_run", Busy, 1);
         chk("t4_done_run", Done, 0);
         tick();
      end
      chk("t4_done", Done, 1);
      chk("t4_q", Quotient, 4);
      chk("t4_r", Remainder, 3);

      // Reset during the third RUN cycle aborts the division.
      launch(5'd23, 5'd5);
      tick();
      tick();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      chk("t5_busy", Busy, 0);
      chk("t5_done", Done, 0);
      chk("t5_dbz", DivByZero, 0);
      chk("t5_q", Quotient, 0);
      chk("t5_r", Remainder, 0);
      tick();
      chk("t5_idle_busy", Busy, 0);
      chk("t5_idle_done", Done, 0);
      run_div("t5_30_4", 5'd30, 5'd4, 5'd7, 5'd2, 1'b1);

      // Start held for two cycles in DONE: only the first is accepted.
      Dividend = 5'd20;
      Divisor  = 5'd3;
      Start    = 1'b1;
      tick();
      tick();
      Start    = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("t6_busy_run", Busy, 1);
         chk("t6_done_run", Done, 0);
         tick();
      end
      chk("t6_done", Done, 1);
      chk("t6_q", Quotient, 6);
      chk("t6_r", Remainder, 2);
      tick();
      chk("t6_no_rerun", Busy, 0);
      chk("t6_still_done", Done, 1);

      for (int i = 0; i < 5000; i++) begin
         a = N'($urandom_range(0, (1 << N) - 1));
         b = N'($urandom_range(0, (1 << N) - 1));
         if (b == '0) begin
            eq = '1;
            er = a;
         end else begin
            eq = a / b;
            er = a % b;
         end
         run_div("rand", a, b, eq, er, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
